// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - data-bus signals between the CPU bus master and the data RAM.
interface mem_bus_master_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-outstanding load/store master for the CPU data bus.
// Aligns address, builds lane enables, replicates store data and extends load data.
module mem_bus_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_signed,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic [31:0]           cpu_rdata,
  mem_bus_master_if.master      bus
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   address_q, address_d;
  logic [3:0]    byteenable_q, byteenable_d;
  logic [31:0]   writedata_q, writedata_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          err_pend_q, err_pend_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    offset_q, offset_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;

  logic          illegal;
  logic [WW-1:0] wait_inc;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  always_comb begin
    illegal  = (cpu_size == 2'b11)
             | ((cpu_size == 2'b01) & cpu_addr[0])
             | ((cpu_size == 2'b10) & (|cpu_addr[1:0]));
    wait_inc = wait_cnt_q + 1'b1;
    shifted  = bus.readdata >> {offset_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    read_d       = read_q;
    write_d      = write_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_pend_d   = err_pend_q;
    rdata_d      = rdata_q;
    offset_d     = offset_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wait_cnt_d   = wait_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          busy_d = 1'b1;
          if (illegal) begin
            err_pend_d = 1'b1;
            state_d    = DONE;
          end else begin
            err_pend_d = 1'b0;
            address_d  = {cpu_addr[31:2], 2'b00};
            case (cpu_size)
              2'b00: begin
                byteenable_d = 4'b0001 << cpu_addr[1:0];
                writedata_d  = {4{cpu_wdata[7:0]}};
              end
              2'b01: begin
                byteenable_d = cpu_addr[1] ? 4'b1100 : 4'b0011;
                writedata_d  = {2{cpu_wdata[15:0]}};
              end
              default: begin
                byteenable_d = 4'b1111;
                writedata_d  = cpu_wdata;
              end
            endcase
            read_d     = ~cpu_we;
            write_d    = cpu_we;
            offset_d   = cpu_addr[1:0];
            size_d     = cpu_size;
            signed_d   = cpu_signed;
            wait_cnt_d = '0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d = DONE;
          end else begin
            lat_cnt_d = 3'(READ_LATENCY);
            state_d   = RDWAIT;
          end
        end else begin
          wait_cnt_d = wait_inc;
          // Abort on the edge that brings the hold-off count to the limit.
          if (wait_inc == WW'(TIMEOUT_CYCLES)) begin
            read_d     = 1'b0;
            write_d    = 1'b0;
            err_pend_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      RDWAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      default: begin
        done_d     = 1'b1;
        err_d      = err_pend_q;
        err_pend_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_pend_q   <= 1'b0;
      rdata_q      <= '0;
      offset_q     <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wait_cnt_q   <= '0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_pend_q   <= err_pend_d;
      rdata_q      <= rdata_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wait_cnt_q   <= wait_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  assign bus.address    = address_q;
  assign bus.byteenable = byteenable_q;
  assign bus.writedata  = writedata_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign cpu_busy       = busy_q;
  assign cpu_done       = done_q;
  assign cpu_err        = err_q;
  assign cpu_rdata      = rdata_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - randomized bench for mem_bus_master with a transaction-level reference model.
module tb_mem_bus_master;
  localparam int RL = 2;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;

  mem_bus_master_if bus ();

  mem_bus_master #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_size   (cpu_size),
    .cpu_signed (cpu_signed),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t0;
    int          t_done;
    int          str_end;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = '0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit legal(input logic [1:0] size, input logic [31:0] addr);
    return (size == 0) || (size == 1 && addr % 2 == 0) || (size == 2 && addr % 4 == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 0) return 4'(1 << off);
    if (size == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] wd);
    if (size == 0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [1:0] size, input bit sgn,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v = rd >> (8 * (addr % 4));
    if (size == 0) begin
      v = v & 32'hFF;
      if (sgn && v >= 128) v = v - 32'd256;
    end else if (size == 1) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Every cycle: bus strobes, payload, busy and the done/err/rdata pulse against the expected transaction.
  always @(negedge clk) begin
    exp_t e;
    bit   se;
    if (exp_q.size() != 0) begin
      e  = exp_q[0];
      se = (cyc >= e.t0) && (cyc <= e.str_end);
      chk("read", 32'(bus.read), 32'(se && !e.we));
      chk("write", 32'(bus.write), 32'(se && e.we));
      if (se) begin
        chk("address", bus.address, e.addr);
        chk("byteenable", 32'(bus.byteenable), 32'(e.be));
        chk("writedata", bus.writedata, e.wd);
      end
      chk("busy", 32'(cpu_busy), 32'(cyc < e.t_done));
      chk("done", 32'(cpu_done), 32'(cyc == e.t_done));
      if (cyc == e.t_done) begin
        chk("err", 32'(cpu_err), 32'(e.err));
        chk("rdata", cpu_rdata, e.rdata);
        void'(exp_q.pop_front());
      end else begin
        chk("err_idle", 32'(cpu_err), 32'd0);
      end
    end else begin
      chk("idle_read", 32'(bus.read), 32'd0);
      chk("idle_write", 32'(bus.write), 32'd0);
      chk("idle_busy", 32'(cpu_busy), 32'd0);
      chk("idle_done", 32'(cpu_done), 32'd0);
      chk("idle_err", 32'(cpu_err), 32'd0);
      chk("idle_rdata", cpu_rdata, model_rdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cpu_req         = 1'b0;
      bus.waitrequest = 1'($urandom);
      bus.readdata    = $urandom;
    end
  endtask

  // w = waitrequest-high edges before accept (>= TO means time out); rst_at = edge index after which reset pulses.
  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int w, input int rst_at);
    exp_t e;
    int   len;
    @(negedge clk);
    cpu_req         = 1'b1;
    cpu_we          = we;
    cpu_size        = size;
    cpu_signed      = sgn;
    cpu_addr        = addr;
    cpu_wdata       = wd;
    bus.waitrequest = 1'($urandom);
    bus.readdata    = $urandom;
    @(posedge clk);
    #1;
    e.t0   = cyc;
    e.we   = we;
    e.addr = addr & 32'hFFFF_FFFC;
    e.be   = exp_be(size, addr);
    e.wd   = exp_wd(size, wd);
    if (!legal(size, addr)) begin
      e.t_done = cyc + 1; e.str_end = cyc - 1; e.err = 1'b1;
    end else if (w >= TO) begin
      e.t_done = cyc + TO + 1; e.str_end = cyc + TO - 1; e.err = 1'b1;
    end else begin
      e.t_done = cyc + w + 2 + (we ? 0 : RL); e.str_end = cyc + w; e.err = 1'b0;
      if (!we) model_rdata = exp_ld(size, sgn, addr, rd);
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
    len = e.t_done - e.t0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      cpu_req         = 1'($urandom);
      cpu_we          = 1'($urandom);
      cpu_size        = 2'($urandom);
      cpu_signed      = 1'($urandom);
      cpu_addr        = $urandom;
      cpu_wdata       = $urandom;
      bus.waitrequest = (k <= w) ? 1'b1 : ((k == w + 1) ? 1'b0 : 1'($urandom));
      bus.readdata    = (k == w + 1 + RL) ? rd : $urandom;
      @(posedge clk);
      if (k == rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_read", 32'(bus.read), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_busy", 32'(cpu_busy), 32'd0);
        chk("rst_done", 32'(cpu_done), 32'd0);
        exp_q.delete();
        model_rdata = '0;
        cpu_req     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata    = '0;
    repeat (3) @(negedge clk);
    chk("reset_address", bus.address, 32'd0);
    chk("reset_byteenable", 32'(bus.byteenable), 32'd0);
    chk("reset_writedata", bus.writedata, 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    reset_n = 1'b1;
    idle(2);

    chk("pin_be_half_hi", 32'(exp_be(2'd1, 32'h22)), 32'h0000000C);
    chk("pin_wd_half", exp_wd(2'd1, 32'h1234), 32'h12341234);
    chk("pin_be_byte3", 32'(exp_be(2'd0, 32'h13)), 32'h00000008);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FF7F01, 0, 0);
    #1 chk("pin_ld_byte_signed", cpu_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FF7F01, 0, 0);
    #1 chk("pin_ld_byte_unsigned", cpu_rdata, 32'h00000080);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234, 32'h0, 3, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0BADF00D, 0, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 0, 0);
    #1 chk("pin_rdata_kept", cpu_rdata, 32'h00000080);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, TO, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, TO - 1, 0);
    #1 chk("pin_ld_after_long_wait", cpu_rdata, 32'hCAFEF00D);
    do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h8001FFFF, 0, 0);
    #1 chk("pin_ld_half_signed", cpu_rdata, 32'hFFFF8001);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h55555555, 0, 2);
    #1 chk("pin_rdata_after_reset", cpu_rdata, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h11223344, 0, 0);
    #1 chk("pin_ld_after_reset", cpu_rdata, 32'h11223344);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      int         w;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0;
      do_req(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom, w, 0);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
